// File: rtl/keypad_debounce_repeat.sv
// keypad_debounce_repeat
//
// Debounces the keypad column scanner's raw key report. The scanner is frozen
// through scan_stop while a key is being qualified, held or released. One
// key_valid pulse is produced per accepted press, and optionally one per
// auto-repeat interval while the key stays held.
//
// Ports
//   clk            in   system clock, all logic on the rising edge
//   rst_n          in   synchronous active-low reset
//   key_code       in   scanner's decoded key (KEY_W)
//   col            in   scanner's active column, active low (COL_W)
//   key_detected   in   scanner reports a key present
//   key_valid      out  one-cycle pulse per accepted press or repeat
//   debounced_key  out  last accepted key code
//   held_col       out  col captured when the press was accepted
//   key_held       out  high while HELD or RELEASE_DB
//   scan_stop      out  high in every state except IDLE
//
// Event semantics: key_valid is a qualifier for debounced_key. It has no
// ready/backpressure. The consumer must take the code in the cycle key_valid
// is high. debounced_key is already valid in that cycle and holds its value
// until the next accepted press.
//
// Debug visibility: current_state (with the IDLE/PRESS_DB/HELD/RELEASE_DB
// localparams) and debounce_cnt are kept as named signals for probing.

module keypad_debounce_repeat #(
    parameter int KEY_W          = 4,
    parameter int COL_W          = 4,
    parameter int PRESS_CYCLES   = 59999,
    parameter int RELEASE_CYCLES = 59999,
    parameter int REPEAT_EN      = 0,
    parameter int REPEAT_DELAY   = 1500000,
    parameter int REPEAT_RATE    = 300000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key_code,
    input  logic [COL_W-1:0] col,
    input  logic             key_detected,
    output logic             key_valid,
    output logic [KEY_W-1:0] debounced_key,
    output logic [COL_W-1:0] held_col,
    output logic             key_held,
    output logic             scan_stop
);

    // One shared counter, wide enough for the largest interval.
    localparam int MAX_PR  = (PRESS_CYCLES > RELEASE_CYCLES) ? PRESS_CYCLES : RELEASE_CYCLES;
    localparam int MAX_RP  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int MAX_CYC = (MAX_PR > MAX_RP) ? MAX_PR : MAX_RP;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] PRESS_TH  = CNT_W'(PRESS_CYCLES);
    localparam logic [CNT_W-1:0] REL_TH    = CNT_W'(RELEASE_CYCLES);
    localparam logic [CNT_W-1:0] DELAY_TH  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RATE_TH   = CNT_W'(REPEAT_RATE);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] PRESS_DB   = 2'd1;
    localparam logic [1:0] HELD       = 2'd2;
    localparam logic [1:0] RELEASE_DB = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE       = IDLE,
        ST_PRESS_DB   = PRESS_DB,
        ST_HELD       = HELD,
        ST_RELEASE_DB = RELEASE_DB
    } state_t;

    // Registers
    state_t             state_q,         state_d;
    logic [CNT_W-1:0]   cnt_q,           cnt_d;
    logic [KEY_W-1:0]   cand_key_q,      cand_key_d;
    logic [COL_W-1:0]   cand_col_q,      cand_col_d;
    logic [KEY_W-1:0]   debounced_key_q, debounced_key_d;
    logic [COL_W-1:0]   held_col_q,      held_col_d;
    logic               key_valid_q,     key_valid_d;
    logic               key_held_q,      key_held_d;
    logic               scan_stop_q,     scan_stop_d;
    logic               rep_started_q,   rep_started_d;

    // Debug-visible names. The next-state logic reads these names.
    state_t             current_state;
    logic [CNT_W-1:0]   debounce_cnt;

    assign current_state = state_q;
    assign debounce_cnt  = cnt_q;

    // Saturating increment: the counter never wraps.
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] rep_th;

    always_comb begin
        cnt_inc = (debounce_cnt == CNT_MAX) ? debounce_cnt : debounce_cnt + CNT_ONE;
        // The first repeat waits REPEAT_DELAY. Later repeats use REPEAT_RATE.
        rep_th  = rep_started_q ? RATE_TH : DELAY_TH;
    end

    always_comb begin
        state_d         = current_state;
        cnt_d           = debounce_cnt;
        cand_key_d      = cand_key_q;
        cand_col_d      = cand_col_q;
        debounced_key_d = debounced_key_q;
        held_col_d      = held_col_q;
        key_valid_d     = 1'b0;
        rep_started_d   = rep_started_q;

        case (current_state)
            ST_IDLE: begin
                if (key_detected) begin
                    cand_key_d = key_code;
                    cand_col_d = col;
                    cnt_d      = CNT_ONE;
                    state_d    = ST_PRESS_DB;
                end
            end

            ST_PRESS_DB: begin
                if (!key_detected) begin
                    // A drop wins, even on the edge that would have accepted.
                    cnt_d   = CNT_ZERO;
                    state_d = ST_IDLE;
                end else if (key_code != cand_key_q) begin
                    // The code changed mid-qualification, so restart on the new key.
                    cand_key_d = key_code;
                    cand_col_d = col;
                    cnt_d      = CNT_ONE;
                end else if (cnt_inc >= PRESS_TH) begin
                    debounced_key_d = cand_key_q;
                    held_col_d      = cand_col_q;
                    key_valid_d     = 1'b1;
                    cnt_d           = CNT_ZERO;
                    rep_started_d   = 1'b0;
                    state_d         = ST_HELD;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_HELD: begin
                // Other codes are ignored while held. Only a drop leaves HELD.
                if (!key_detected) begin
                    cnt_d   = CNT_ONE;
                    state_d = ST_RELEASE_DB;
                end else if (REPEAT_EN != 0) begin
                    if (cnt_inc >= rep_th) begin
                        key_valid_d   = 1'b1;
                        cnt_d         = CNT_ZERO;
                        rep_started_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end

            ST_RELEASE_DB: begin
                if (key_detected && (key_code == debounced_key_q)) begin
                    // A glitch on the held key: resume holding, and the repeat timing starts over.
                    cnt_d         = CNT_ZERO;
                    rep_started_d = 1'b0;
                    state_d       = ST_HELD;
                end else if (debounce_cnt >= REL_TH) begin
                    // Test the registered count so that IDLE is entered
                    // RELEASE_CYCLES edges after the first edge that saw the drop.
                    cnt_d   = CNT_ZERO;
                    state_d = ST_IDLE;
                end else begin
                    // A different code counts as still released.
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                cnt_d   = CNT_ZERO;
                state_d = ST_IDLE;
            end
        endcase

        key_held_d  = (state_d == ST_HELD) || (state_d == ST_RELEASE_DB);
        scan_stop_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            cnt_q           <= CNT_ZERO;
            cand_key_q      <= '0;
            cand_col_q      <= '1;
            debounced_key_q <= '0;
            held_col_q      <= '1;
            key_valid_q     <= 1'b0;
            key_held_q      <= 1'b0;
            scan_stop_q     <= 1'b0;
            rep_started_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            cand_key_q      <= cand_key_d;
            cand_col_q      <= cand_col_d;
            debounced_key_q <= debounced_key_d;
            held_col_q      <= held_col_d;
            key_valid_q     <= key_valid_d;
            key_held_q      <= key_held_d;
            scan_stop_q     <= scan_stop_d;
            rep_started_q   <= rep_started_d;
        end
    end

    assign key_valid     = key_valid_q;
    assign debounced_key = debounced_key_q;
    assign held_col      = held_col_q;
    assign key_held      = key_held_q;
    assign scan_stop     = scan_stop_q;

endmodule

// File: tb/tb_keypad_debounce_repeat.sv
// Bench for keypad_debounce_repeat. dut0 has auto-repeat off. dut1 has
// auto-repeat on and stays in reset until the repeat section. Each expected
// key_valid pulse is queued as {edge number, key code} when the stimulus is
// driven, then popped and compared when the pulse shows up.

module tb_keypad_debounce_repeat;

    localparam int PC = 8;
    localparam int RC = 4;
    localparam int RD = 20;
    localparam int RR = 5;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_PRESS_DB   = 2'd1;
    localparam logic [1:0] ST_HELD       = 2'd2;
    localparam logic [1:0] ST_RELEASE_DB = 2'd3;

    // Clock and reset
    logic clk = 1'b0;
    logic rst_n;
    logic rst1_n;
    always #5 clk = ~clk;

    logic [27:0] edge_n = '0;
    always @(posedge clk) edge_n <= edge_n + 28'd1;

    // Stimulus and DUT outputs
    logic [3:0] key_code;
    logic [3:0] col;
    logic       key_detected;

    logic       kv0, held0, ss0;
    logic [3:0] deb0, hcol0;
    logic       kv1, held1, ss1;
    logic [3:0] deb1, hcol1;

    keypad_debounce_repeat #(
        .KEY_W(4), .COL_W(4), .PRESS_CYCLES(PC), .RELEASE_CYCLES(RC),
        .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .key_code(key_code), .col(col),
        .key_detected(key_detected), .key_valid(kv0), .debounced_key(deb0),
        .held_col(hcol0), .key_held(held0), .scan_stop(ss0)
    );

    keypad_debounce_repeat #(
        .KEY_W(4), .COL_W(4), .PRESS_CYCLES(PC), .RELEASE_CYCLES(RC),
        .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut1 (
        .clk(clk), .rst_n(rst1_n), .key_code(key_code), .col(col),
        .key_detected(key_detected), .key_valid(kv1), .debounced_key(deb1),
        .held_col(hcol1), .key_held(held1), .scan_stop(ss1)
    );

    // Scoreboard
    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp0_q[$];
    logic [31:0] exp1_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, act, exp, edge_n);
    endtask

    logic [31:0] pop0, pop1;

    always @(negedge clk) begin
        if (kv0 === 1'b1) begin
            if (exp0_q.size() == 0) check("spurious_pulse0", 32'(kv0), 32'd0);
            else begin
                pop0 = exp0_q.pop_front();
                check("pulse0", {edge_n, deb0}, pop0);
            end
        end
    end

    always @(negedge clk) begin
        if (kv1 === 1'b1) begin
            if (exp1_q.size() == 0) check("spurious_pulse1", 32'(kv1), 32'd0);
            else begin
                pop1 = exp1_q.pop_front();
                check("pulse1", {edge_n, deb1}, pop1);
            end
        end
    end

    // Driver tasks
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic det, input logic [3:0] code, input logic [3:0] c);
        key_detected = det;
        key_code     = code;
        col          = c;
    endtask

    // The pulse comes out of the edge PC-1 after the first sampling edge.
    task automatic push_press0(input logic [3:0] code);
        logic [27:0] e0;
        e0 = edge_n + 28'd1;
        exp0_q.push_back({e0 + 28'(PC - 1), code});
    endtask

    task automatic check_reset_vals(input string tag, input logic [1:0] st, input logic [31:0] cnt,
                                    input logic kv, input logic [3:0] deb, input logic [3:0] hc,
                                    input logic kh, input logic ss);
        check({tag, "_state"}, 32'(st), 32'(ST_IDLE));
        check({tag, "_cnt"}, cnt, 32'd0);
        check({tag, "_key_valid"}, 32'(kv), 32'd0);
        check({tag, "_debounced_key"}, 32'(deb), 32'd0);
        check({tag, "_held_col"}, 32'(hc), 32'hf);
        check({tag, "_key_held"}, 32'(kh), 32'd0);
        check({tag, "_scan_stop"}, 32'(ss), 32'd0);
    endtask

    logic [27:0] e_rep;

    initial begin
        rst_n  = 1'b0;
        rst1_n = 1'b0;
        drive(1'b0, 4'h0, 4'hf);

        // Reset and idle
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(5);
        check_reset_vals("rst0", dut0.current_state, 32'(dut0.debounce_cnt),
                         kv0, deb0, hcol0, held0, ss0);
        check_reset_vals("rst1", dut1.current_state, 32'(dut1.debounce_cnt),
                         kv1, deb1, hcol1, held1, ss1);

        // Clean press of key 5, then lock against key A
        push_press0(4'h5);
        drive(1'b1, 4'h5, 4'b1101);
        wait_cyc(1);
        check("press_scan_stop", 32'(ss0), 32'd1);
        check("press_state_pdb", 32'(dut0.current_state), 32'(ST_PRESS_DB));
        wait_cyc(PC);
        check("press_debounced", 32'(deb0), 32'h5);
        check("press_held_col", 32'(hcol0), 32'b1101);
        check("press_state_held", 32'(dut0.current_state), 32'(ST_HELD));
        check("press_key_held", 32'(held0), 32'd1);
        drive(1'b1, 4'hA, 4'b1011);
        wait_cyc(6);
        check("lock_debounced", 32'(deb0), 32'h5);
        check("lock_state", 32'(dut0.current_state), 32'(ST_HELD));

        // Release, with a different code seen mid-release
        drive(1'b0, 4'h0, 4'hf);
        wait_cyc(1);
        drive(1'b1, 4'h2, 4'b1110);
        wait_cyc(2);
        check("rel_other_code_state", 32'(dut0.current_state), 32'(ST_RELEASE_DB));
        drive(1'b0, 4'h0, 4'hf);
        wait_cyc(1);
        check("rel_before_idle_held", 32'(held0), 32'd1);
        wait_cyc(1);
        check("rel_idle_state", 32'(dut0.current_state), 32'(ST_IDLE));
        check("rel_idle_key_held", 32'(held0), 32'd0);
        check("rel_idle_scan_stop", 32'(ss0), 32'd0);

        // Bounce: key 3 for 5 cycles, then key 7 for PC cycles
        drive(1'b1, 4'h3, 4'b0111);
        wait_cyc(5);
        push_press0(4'h7);
        drive(1'b1, 4'h7, 4'b1011);
        wait_cyc(PC);
        drive(1'b0, 4'h0, 4'hf);
        wait_cyc(1);
        check("bounce_debounced", 32'(deb0), 32'h7);
        wait_cyc(RC);
        check("bounce_release_idle", 32'(dut0.current_state), 32'(ST_IDLE));

        // Short press of C
        drive(1'b1, 4'hC, 4'b1110);
        wait_cyc(5);
        drive(1'b0, 4'h0, 4'hf);
        wait_cyc(1);
        check("short_idle", 32'(dut0.current_state), 32'(ST_IDLE));
        check("short_scan_stop", 32'(ss0), 32'd0);
        check("short_debounced", 32'(deb0), 32'h7);

        // Drop on the edge that would have accepted
        drive(1'b1, 4'hB, 4'b1101);
        wait_cyc(PC - 1);
        drive(1'b0, 4'h0, 4'hf);
        wait_cyc(1);
        check("dropwin_idle", 32'(dut0.current_state), 32'(ST_IDLE));
        check("dropwin_debounced", 32'(deb0), 32'h7);
        wait_cyc(2);

        // Release glitch on key F
        push_press0(4'hF);
        drive(1'b1, 4'hF, 4'b0111);
        wait_cyc(PC + 1);
        drive(1'b0, 4'h0, 4'hf);
        wait_cyc(2);
        check("glitch_rel_state", 32'(dut0.current_state), 32'(ST_RELEASE_DB));
        check("glitch_rel_key_held", 32'(held0), 32'd1);
        drive(1'b1, 4'hF, 4'b0111);
        wait_cyc(1);
        check("glitch_back_held", 32'(dut0.current_state), 32'(ST_HELD));
        check("glitch_key_held", 32'(held0), 32'd1);
        check("glitch_debounced", 32'(deb0), 32'hF);
        drive(1'b0, 4'h0, 4'hf);
        wait_cyc(RC);
        check("full_rel_still_held", 32'(held0), 32'd1);
        wait_cyc(1);
        check("full_rel_idle", 32'(dut0.current_state), 32'(ST_IDLE));
        check("full_rel_key_held", 32'(held0), 32'd0);

        // Auto-repeat on dut1, with dut0 running alongside as the no-repeat reference
        rst1_n = 1'b1;
        wait_cyc(2);
        e_rep = edge_n + 28'd1;
        push_press0(4'h9);
        exp1_q.push_back({e_rep + 28'(PC - 1), 4'h9});
        for (int k = 0; k < 5; k++)
            exp1_q.push_back({e_rep + 28'(PC - 1 + RD + k * RR), 4'h9});
        drive(1'b1, 4'h9, 4'b1011);
        wait_cyc(PC + RD + 4 * RR);
        check("rep_state_held", 32'(dut1.current_state), 32'(ST_HELD));
        check("rep_held_col", 32'(hcol1), 32'b1011);
        // Reset lands on the edge where the next repeat would have fired
        wait_cyc(RR - 1);
        rst_n  = 1'b0;
        rst1_n = 1'b0;
        wait_cyc(1);
        check_reset_vals("midrst0", dut0.current_state, 32'(dut0.debounce_cnt),
                         kv0, deb0, hcol0, held0, ss0);
        check_reset_vals("midrst1", dut1.current_state, 32'(dut1.debounce_cnt),
                         kv1, deb1, hcol1, held1, ss1);
        wait_cyc(2);
        drive(1'b0, 4'h0, 4'hf);
        rst_n  = 1'b1;
        rst1_n = 1'b1;
        wait_cyc(3);

        check("missing_pulses0", 32'(exp0_q.size()), 32'd0);
        check("missing_pulses1", 32'(exp1_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
